// File: rtl/count_seq_ctrl_pkg.sv
// Shared types for the bounded up/down count sequencer.
// Holds the count width, run modes and FSM states.
package count_pkg;

  localparam int W = 8;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP1 = 2'b00;
  localparam mode_t MODE_DN1 = 2'b01;
  localparam mode_t MODE_PP  = 2'b10;
  localparam mode_t MODE_RLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic is_one_shot(mode_t m);
    return ~m[1];
  endfunction

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Control/status bundle between a run initiator and the sequencer.
// master drives the run request, slave reports count and status.
interface count_seq_ctrl_if;
  import count_pkg::*;

  logic         start;
  logic         stop;
  logic         pause;
  mode_t        mode;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         dir;
  logic         wrap;
  logic         err;

  modport master (
    output start, stop, pause,
    output mode, lo, hi,
    input  cnt, busy, done,
    input  dir, wrap, err
  );

  modport slave (
    input  start, stop, pause,
    input  mode, lo, hi,
    output cnt, busy, done,
    output dir, wrap, err
  );

endinterface

// File: rtl/count_udl.sv
// Loadable 8-bit up/down counter; load beats enable.
// ud=1 counts up, ud=0 counts down.
module count_udl
  import count_pkg::*;
(
  input  logic         ck,
  input  logic         reset,
  input  logic         en,
  input  logic         ud,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= d;
    end else if (en) begin
      cnt_q <= ud ? cnt_q + 1'b1
                  : cnt_q - 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Run sequencer around count_udl: bounds, modes, pause/stop.
// Counter controls are combinational from state and count.
module count_seq_ctrl
  import count_pkg::*;
(
  input  logic ck,
  input  logic reset,
  count_seq_ctrl_if.slave bus
);

  state_e       state_q;
  logic [W-1:0] lo_q;
  logic [W-1:0] hi_q;
  mode_t        mode_q;
  logic         dir_q;
  logic         wrap_q;
  logic         err_q;

  logic         en;
  logic         ud;
  logic         ld;
  logic [W-1:0] d;
  logic [W-1:0] cnt;
  logic         at_hi;
  logic         at_lo;
  logic         term;
  logic         flip;

  count_udl u_cnt (
    .ck    (ck),
    .reset (reset),
    .en    (en),
    .ud    (ud),
    .load  (ld),
    .d     (d),
    .cnt   (cnt)
  );

  assign at_hi = (cnt == hi_q);
  assign at_lo = (cnt == lo_q);

  always_comb begin
    en   = 1'b0;
    ud   = dir_q;
    ld   = 1'b0;
    d    = lo_q;
    term = 1'b0;
    flip = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (!bus.stop) begin
          ld = 1'b1;
          d  = (mode_q == MODE_DN1) ? hi_q : lo_q;
        end
      end
      ST_RUN: begin
        if (!bus.stop && !bus.pause) begin
          unique case (mode_q)
            MODE_UP1: begin
              term = at_hi;
              en   = ~at_hi;
            end
            MODE_DN1: begin
              term = at_lo;
              en   = ~at_lo;
            end
            MODE_PP: begin
              // Turn and step the other way in one cycle.
              // A degenerate lo==hi range just holds.
              term = dir_q ? at_hi : at_lo;
              flip = term & ~(at_hi & at_lo);
              en   = ~(at_hi & at_lo);
              ud   = term ? ~dir_q : dir_q;
            end
            MODE_RLD: begin
              term = at_hi;
              en   = ~at_hi;
              ld   = at_hi;
              d    = lo_q;
            end
          endcase
        end
      end
      ST_IDLE: ;
      ST_DONE: ;
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= MODE_UP1;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.stop) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              if (bus.lo <= bus.hi) begin
                lo_q    <= bus.lo;
                hi_q    <= bus.hi;
                mode_q  <= bus.mode;
                dir_q   <= (bus.mode != MODE_DN1);
                state_q <= ST_LOAD;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (term) begin
              if (is_one_shot(mode_q)) begin
                state_q <= ST_DONE;
              end else begin
                wrap_q <= 1'b1;
                if (flip) dir_q <= ~dir_q;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cnt  = cnt;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.dir  = dir_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule
